aes_enc_round_ctrl: RTL and testbench

//   Iterative AES encryption sequencer: owns the 128-bit state register and round counter, and

---
 rtl/aes_enc_round_ctrl.sv | 146 ++++++++++++++
 tb/tb_aes_enc_round_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_round_ctrl.sv
// rtl/aes_enc_round_ctrl.sv - iterative AES encryption round sequencer, one round per clock
// Owns the 128-bit state and round counter; round keys are fetched from an external store by index.

module aes_enc_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [3:0]   round
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    fsm_t         fsm;
    logic [127:0] state_reg;
    logic [3:0]   round_q;
    logic [127:0] sr_q;
    logic [127:0] mc_q;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254, with 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] r;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        b = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            b = {b[6:0], b[7]};
            r = r ^ b;
        end
        return r ^ 8'h63;
    endfunction

    // Byte n lives at [127-8n -: 8]; byte index = row + 4*col
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03);
            o[103-32*c -: 8] = gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02);
        end
        return o;
    endfunction

    assign sr_q = sub_shift(state_reg);
    assign mc_q = mix_cols(sr_q);

    always_comb begin
        rk_idx = 4'd0;
        case (fsm)
            ROUND:   rk_idx = round_q;
            FINAL:   rk_idx = 4'(NR);
            default: rk_idx = 4'd0;
        endcase
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm != IDLE);
    assign out_data  = state_reg;
    assign round     = round_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_reg <= '0;
            round_q   <= 4'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_data ^ rk;
                        round_q   <= 4'd1;
                        fsm       <= (NR == 1) ? FINAL : ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= mc_q ^ rk;
                    round_q   <= round_q + 4'd1;
                    if (round_q == 4'(NR - 1)) fsm <= FINAL;
                end
                FINAL: begin
                    // Last round skips MixColumns
                    state_reg <= sr_q ^ rk;
                    round_q   <= 4'd0;
                    fsm       <= DONE;
                end
                DONE: begin
                    if (out_ready) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// tb/tb_aes_enc_round_ctrl.sv - self-checking bench for aes_enc_round_ctrl (NR=10 and NR=14)
// Reference is a byte-array AES model with its own key expansion and S-box generator.

module tb_aes_enc_round_ctrl;

    localparam int NR = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_data, rk, out_data;
    logic [3:0]   rk_idx, round;

    logic         in_valid14, in_ready14, out_valid14, out_ready14, busy14;
    logic [127:0] in_data14, rk14, out_data14;
    logic [3:0]   rk_idx14, round14;

    logic [127:0] ks10 [0:15];
    logic [127:0] ks14 [0:15];
    logic [7:0]   sbox [0:255];

    int tests_run = 0;
    int tests_failed = 0;

    assign rk   = ks10[rk_idx];
    assign rk14 = ks14[rk_idx14];

    aes_enc_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .round(round)
    );

    aes_enc_round_ctrl #(.NR(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14), .in_data(in_data14),
        .rk_idx(rk_idx14), .rk(rk14), .out_valid(out_valid14), .out_ready(out_ready14),
        .out_data(out_data14), .busy(busy14), .round(round14)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Walks p over powers of 3 and q over powers of 3^-1 so q = p^-1, then applies the affine map
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    task automatic expand(input logic [255:0] key, input int nk, input int nr, output logic [127:0] ks [0:15]);
        logic [31:0] w [0:63];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 64; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            ks[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input int nr, input logic [127:0] ks [0:15]);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[0][127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row+4*col] = t[row+4*((col+row)%4)];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tests_run++;
        if ({in_ready, out_valid, busy, rk_idx, round} !== {3'b100, 4'd0, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rdy/vld/busy/idx/round=%b/%b/%b/%0d/%0d want 1/0/0/0/0", in_ready, out_valid, busy, rk_idx, round);
        end
        tests_run++;
        if (out_data !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got rdy/vld/busy=%b%b%b want 100", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_fips128();
        logic [127:0] pt;
        int  n;
        bit  seq_ok;
        pt = 128'h00112233445566778899aabbccddeeff;
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NR, ks10);
        tests_run++;
        if (rk_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL idle_rk_idx: got %0d want 0", rk_idx);
        end
        in_data = pt; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0; seq_ok = 1'b1;
        while (!out_valid && n < 40) begin
            n++;
            if (rk_idx !== 4'(n)) seq_ok = 1'b0;
            tick();
        end
        tests_run++;
        if (n != NR) begin
            tests_failed++;
            $display("FAIL fips128_latency: got %0d want %0d", n, NR);
        end
        tests_run++;
        if (!seq_ok) begin
            tests_failed++;
            $display("FAIL fips128_rk_seq: got out-of-order rk_idx want 1..%0d", NR);
        end
        tests_run++;
        if (out_data !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            tests_failed++;
            $display("FAIL fips128_ct: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", out_data);
        end
        tests_run++;
        if (out_data !== model_enc(pt, NR, ks10) || rk_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL fips128_model: got %h idx %0d want %h idx 0", out_data, rk_idx, model_enc(pt, NR, ks10));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL fips128_release: got rdy/vld=%b%b want 10", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk [2];
        logic [127:0] expq [$];
        logic [127:0] got [$];
        int  acc [$];
        int  idxs [$];
        int  sent;
        int  a0;
        bit  seq_ok;
        expand({rnd128(), 128'h0}, 4, NR, ks10);
        blk[0] = rnd128(); blk[1] = rnd128();
        sent = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = blk[0];
        for (int c = 0; c < 40; c++) begin
            idxs.push_back(int'(rk_idx));
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && in_ready) begin
                acc.push_back(c);
                expq.push_back(model_enc(in_data, NR, ks10));
                sent++;
            end
            tick();
            if (sent == 1) in_data = blk[1];
            if (sent >= 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        tests_run++;
        if (acc.size() != 2 || (acc.size() == 2 && acc[1] - acc[0] != NR + 2)) begin
            tests_failed++;
            $display("FAIL b2b_interval: got %0d accepts gap %0d want 2 accepts gap %0d",
                     acc.size(), (acc.size() == 2) ? acc[1] - acc[0] : -1, NR + 2);
        end
        tests_run++;
        if (got.size() != 2 || (got.size() == 2 && (got[0] !== expq[0] || got[1] !== expq[1]))) begin
            tests_failed++;
            $display("FAIL b2b_data: got %0d outputs want 2 matching the model", got.size());
        end
        // Expected index trace from the first accept: 0, 1..NR, 0 (DONE), 0 (IDLE)
        seq_ok = (acc.size() >= 1);
        if (seq_ok) begin
            a0 = acc[0];
            for (int k = 0; k <= NR + 2; k++) begin
                if (idxs[a0 + k] != ((k >= 1 && k <= NR) ? k : 0)) seq_ok = 1'b0;
            end
        end
        tests_run++;
        if (!seq_ok) begin
            tests_failed++;
            $display("FAIL b2b_rk_seq: got trace not matching want 0,1..%0d,0,0", NR);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, exp_ct;
        int n;
        int bad;
        expand({rnd128(), 128'h0}, 4, NR, ks10);
        pt = rnd128();
        exp_ct = model_enc(pt, NR, ks10);
        in_data = pt; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        tests_run++;
        if (n != NR || out_data !== exp_ct) begin
            tests_failed++;
            $display("FAIL bp_result: got lat %0d ct %h want lat %0d ct %h", n, out_data, NR, exp_ct);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rnd128();
            tick();
            if ({out_valid, in_ready, busy} !== 3'b101 || out_data !== exp_ct) bad++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            tests_failed++;
            $display("FAIL bp_release: got rdy/vld/busy=%b%b%b want 100", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt;
        int n;
        int leaks;
        expand({rnd128(), 128'h0}, 4, NR, ks10);
        in_data = rnd128(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round != 4'd5 && n < 40) begin tick(); n++; end
        tests_run++;
        if (round != 4'd5) begin
            tests_failed++;
            $display("FAIL mid_round5: got round %0d want 5", round);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 128'h0 || round !== 4'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: got rdy/vld/busy=%b%b%b data %h round %0d want 100 0 0",
                     in_ready, out_valid, busy, out_data, round);
        end
        leaks = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (out_valid !== 1'b0) leaks++;
        end
        tests_run++;
        if (leaks != 0) begin
            tests_failed++;
            $display("FAIL mid_no_partial: got %0d valid cycles want 0", leaks);
        end
        pt = rnd128();
        in_data = pt; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        tests_run++;
        if (n != NR || out_data !== model_enc(pt, NR, ks10)) begin
            tests_failed++;
            $display("FAIL mid_recover: got lat %0d ct %h want lat %0d ct %h", n, out_data, NR, model_enc(pt, NR, ks10));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_nr14();
        logic [127:0] pt [2];
        logic [127:0] ref_ct;
        int n;
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, ks14);
        pt[0] = 128'h00112233445566778899aabbccddeeff;
        pt[1] = rnd128();
        for (int b = 0; b < 2; b++) begin
            ref_ct = (b == 0) ? 128'h8ea2b7ca516745bfeafc49904b496089 : model_enc(pt[1], 14, ks14);
            in_data14 = pt[b]; in_valid14 = 1'b1;
            tick();
            in_valid14 = 1'b0;
            n = 0;
            while (!out_valid14 && n < 40) begin tick(); n++; end
            tests_run++;
            if (n != 14) begin
                tests_failed++;
                $display("FAIL nr14_latency[%0d]: got %0d want 14", b, n);
            end
            tests_run++;
            if (out_data14 !== ref_ct) begin
                tests_failed++;
                $display("FAIL nr14_ct[%0d]: got %h want %h", b, out_data14, ref_ct);
            end
            out_ready14 = 1'b1;
            tick();
            out_ready14 = 1'b0;
        end
    endtask

    task automatic test_hold_valid();
        logic [127:0] expq [$];
        logic [127:0] e;
        int  accepts;
        int  outs;
        bit  took;
        expand({rnd128(), 128'h0}, 4, NR, ks10);
        accepts = 0; outs = 0;
        in_valid = 1'b1; in_data = rnd128();
        for (int c = 0; c < 200; c++) begin
            if (c == 170) in_valid = 1'b0;
            took = in_valid && in_ready;
            if (took) begin
                expq.push_back(model_enc(in_data, NR, ks10));
                accepts++;
            end
            if (out_valid && out_ready) begin
                outs++;
                tests_run++;
                if (expq.size() == 0) begin
                    tests_failed++;
                    $display("FAIL hold_dup: got extra output %h want none", out_data);
                end else begin
                    e = expq.pop_front();
                    if (out_data !== e) begin
                        tests_failed++;
                        $display("FAIL hold_ct: got %h want %h", out_data, e);
                    end
                end
            end
            tick();
            if (took) in_data = rnd128();
            out_ready = (c >= 170) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        out_ready = 1'b0;
        tests_run++;
        if (expq.size() != 0 || accepts < 4 || outs != accepts) begin
            tests_failed++;
            $display("FAIL hold_count: got accepts %0d outputs %0d pending %0d want equal with none pending",
                     accepts, outs, expq.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid14 = 1'b0; in_data14 = '0; out_ready14 = 1'b0;
        build_sbox();
        for (int i = 0; i < 16; i++) begin ks10[i] = '0; ks14[i] = '0; end
        tick();
        test_reset();
        test_fips128();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_nr14();
        test_hold_valid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
